// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall controller for the 5-stage RV32 core.
//   Resolves load-use hazards (one bubble), taken-branch redirects (flush of
//   the two wrong-path instructions), multi-cycle EX operations (internal
//   IDLE/BUSY FSM with a down-counter) and data-memory wait states (full
//   freeze). Also keeps saturating perf counters of bubbles and redirects.
//
// Ports
//   clk, rst_n          : core clock (rising edge), async active-low reset
//   id_rs1/id_rs2       : source register fields of the instruction in ID
//   id_uses_rs1/rs2     : ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd  : EX instruction is a load, and its destination
//   ex_branch_taken     : EX resolved a taken branch/jump this cycle
//   ex_mc_start         : first EX cycle of a multi-cycle op
//   mem_wait            : data memory not ready, MEM must hold
//   cnt_clr             : synchronous clear of the perf counters
//   pc_stall ...        : stall/flush controls of PC and pipeline registers
//   mc_busy             : multi-cycle FSM is in BUSY
//   bubble_cnt          : load-use bubbles inserted (saturating)
//   flush_cnt           : branch redirects taken (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MC_LAT = 4,   // EX occupancy of a multi-cycle op, 2..255
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mem_wait,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The start cycle is spent in IDLE, so BUSY only needs MC_LAT-1 cycles,
    // the last of which releases the stall.
    localparam logic [7:0] MC_LOAD = 8'(MC_LAT - 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [7:0] mc_cnt;

    logic lu;
    logic mc_stall;
    logic br_act;
    logic lu_act;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign mc_stall = ((state == IDLE) && ex_mc_start) ||
                      ((state == BUSY) && (mc_cnt != 8'd0));

    // Which hazard wins this cycle; these also qualify the perf counters.
    assign br_act = rst_n && !mem_wait && !mc_stall && ex_branch_taken;
    assign lu_act = rst_n && !mem_wait && !mc_stall && !ex_branch_taken && lu;

    assign mc_busy = (state == BUSY);

    // Outputs are forced low while rst_n is asserted so that live inputs
    // cannot produce a stall during reset.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst_n) begin
            if (mem_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (mc_stall) begin
                // EX holds the op; MEM receives bubbles meanwhile.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (br_act) begin
                // Any coincident load-use belongs to the wrong path.
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (lu_act) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end
    end

    // Multi-cycle FSM; a memory wait freezes it along with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mc_cnt <= 8'd0;
        end else if (!mem_wait) begin
            case (state)
                IDLE: begin
                    if (ex_mc_start) begin
                        state  <= BUSY;
                        mc_cnt <= MC_LOAD;
                    end
                end
                BUSY: begin
                    if (mc_cnt != 8'd0) begin
                        mc_cnt <= mc_cnt - 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mc_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Perf counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lu_act) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
            if (br_act) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Two instances share the stimulus:
//   one with 16-bit counters and one with 2-bit counters for saturation.
//   The reference tracks a multi-cycle op by its age (cycle index within
//   the op) and keeps the perf counts as unbounded integers, clamped to the
//   counter width only when compared.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MC_LAT = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       ex_branch_taken, ex_mc_start, mem_wait, cnt_clr;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, ex_mem_flush, mc_busy;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall;
    logic        s_id_ex_flush, s_ex_mem_stall, s_ex_mem_flush, s_mc_busy;
    logic [1:0]  s_bubble_cnt, s_flush_cnt;

    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
        .mc_busy(mc_busy), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
        .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
        .ex_mem_stall(s_ex_mem_stall), .ex_mem_flush(s_ex_mem_flush),
        .mc_busy(s_mc_busy), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, ex_mem_flush, mc_busy}
    logic [7:0] dut_o, sat_o;
    assign dut_o = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                    id_ex_flush, ex_mem_stall, ex_mem_flush, mc_busy};
    assign sat_o = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall,
                    s_id_ex_flush, s_ex_mem_stall, s_ex_mem_flush, s_mc_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    bit m_active;     // a multi-cycle op is past its start cycle
    int m_age;        // cycle index within the op (start cycle is 0)
    int m_bub, m_fl;  // unbounded event counts since last clear/reset
    bit e_lu, e_br;   // which counted hazard is active this cycle
    logic [7:0] e_o;

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_eval();
        bit lu, mcs;
        lu  = ex_mem_read && ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        mcs = m_active ? (m_age <= MC_LAT - 2) : ex_mc_start;
        e_o = 8'h00;
        e_lu = 0;
        e_br = 0;
        if (rst_n) begin
            e_o[0] = m_active;
            if (mem_wait) begin
                e_o[7] = 1; e_o[6] = 1; e_o[4] = 1; e_o[2] = 1;
            end else if (mcs) begin
                e_o[7] = 1; e_o[6] = 1; e_o[4] = 1; e_o[1] = 1;
            end else if (ex_branch_taken) begin
                e_o[5] = 1; e_o[3] = 1; e_br = 1;
            end else if (lu) begin
                e_o[7] = 1; e_o[6] = 1; e_o[3] = 1; e_lu = 1;
            end
        end
    endtask

    task automatic model_advance();
        if (!rst_n) return;
        if (!mem_wait) begin
            if (!m_active && ex_mc_start) begin
                m_active = 1;
                m_age    = 1;
            end else if (m_active) begin
                if (m_age == MC_LAT - 1) m_active = 0;
                else m_age++;
            end
        end
        if (cnt_clr) begin
            m_bub = 0;
            m_fl  = 0;
        end else begin
            if (e_lu) m_bub++;
            if (e_br) m_fl++;
        end
    endtask

    task automatic check_now();
        #1;
        if (!rst_n) begin
            m_active = 0; m_age = 0; m_bub = 0; m_fl = 0;
        end
        model_eval();
        cmp("outs", {24'd0, dut_o}, {24'd0, e_o});
        cmp("outs_w2", {24'd0, sat_o}, {24'd0, e_o});
        cmp("bubble_cnt", {16'd0, bubble_cnt}, clamp(m_bub, 65535));
        cmp("flush_cnt", {16'd0, flush_cnt}, clamp(m_fl, 65535));
        cmp("sat_cnts", {28'd0, s_bubble_cnt, s_flush_cnt},
            (clamp(m_bub, 3) << 2) | clamp(m_fl, 3));
    endtask

    // Caller drives inputs at the falling edge, then calls step().
    task automatic step();
        check_now();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle_in();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
        ex_mc_start = 0; mem_wait = 0; cnt_clr = 0;
    endtask

    task automatic lu_in();
        idle_in();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    endtask

    task automatic pin_outs(input string nm, input logic [7:0] exp);
        #1;
        cmp(nm, {24'd0, dut_o}, {24'd0, exp});
    endtask

    // Multi-cycle sequence with optional memory wait; exp lists per-cycle outputs.
    task automatic mc_seq(input string nm, input int ncyc, input int wait_lo,
                          input int wait_hi, input logic [7:0] exp [0:7]);
        for (int c = 0; c < ncyc; c++) begin
            idle_in();
            ex_mc_start = (c == 0);
            mem_wait    = (c >= wait_lo && c <= wait_hi);
            pin_outs(nm, exp[c]);
            step();
        end
    endtask

    initial begin
        logic [7:0] t3 [0:7];
        logic [7:0] t5 [0:7];
        m_active = 0; m_age = 0; m_bub = 0; m_fl = 0;
        idle_in();
        rst_n = 0;
        @(negedge clk);

        // Reset state, with a load-use pattern on the inputs.
        lu_in();
        pin_outs("reset_outs", 8'h00);
        cmp("reset_bub", {16'd0, bubble_cnt}, 32'd0);
        step();
        rst_n = 1;
        idle_in();
        step();

        // Load-use: one bubble.
        lu_in();
        pin_outs("lu_outs", 8'b1100_1000);
        step();
        idle_in();
        pin_outs("lu_release", 8'h00);
        cmp("lu_bub", {16'd0, bubble_cnt}, 32'd1);
        step();

        // Load to x0 never stalls.
        idle_in();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        pin_outs("x0_outs", 8'h00);
        step();
        cmp("x0_bub", {16'd0, bubble_cnt}, 32'd1);

        // Multi-cycle op, MC_LAT=4.
        t3 = '{8'b1101_0010, 8'b1101_0011, 8'b1101_0011, 8'b0000_0001,
               8'h00, 8'h00, 8'h00, 8'h00};
        mc_seq("mc_seq", 5, 99, 99, t3);

        // Branch coincident with load-use.
        lu_in();
        ex_branch_taken = 1;
        pin_outs("br_lu_outs", 8'b0010_1000);
        step();
        idle_in();
        cmp("br_flush", {16'd0, flush_cnt}, 32'd1);
        cmp("br_bub", {16'd0, bubble_cnt}, 32'd1);

        // Memory wait during BUSY freezes the op.
        t5 = '{8'b1101_0010, 8'b1101_0101, 8'b1101_0101, 8'b1101_0011,
               8'b1101_0011, 8'b0000_0001, 8'h00, 8'h00};
        mc_seq("mc_wait", 7, 1, 2, t5);

        // Reset in the middle of BUSY.
        idle_in();
        ex_mc_start = 1;
        step();
        idle_in();
        step();
        lu_in();
        ex_mc_start = 1;
        rst_n = 0;
        pin_outs("rst_mid_outs", 8'h00);
        cmp("rst_mid_cnt", {16'd0, flush_cnt}, 32'd0);
        step();
        rst_n = 1;
        idle_in();
        pin_outs("rst_after", 8'h00);
        step();

        // Saturation of the 2-bit counters and clear precedence.
        for (int i = 0; i < 5; i++) begin
            lu_in();
            step();
            idle_in();
            step();
        end
        cmp("sat_bub_w2", {30'd0, s_bubble_cnt}, 32'd3);
        cmp("sat_bub_w16", {16'd0, bubble_cnt}, 32'd5);
        lu_in();
        cnt_clr = 1;
        step();
        idle_in();
        cmp("clr_bub_w2", {30'd0, s_bubble_cnt}, 32'd0);
        cmp("clr_bub_w16", {16'd0, bubble_cnt}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 99) < 15);
            ex_mc_start     = ($urandom_range(0, 99) < 10);
            mem_wait        = ($urandom_range(0, 99) < 15);
            cnt_clr         = !mem_wait && ($urandom_range(0, 99) < 2);
            rst_n           = !($urandom_range(0, 999) < 3);
            step();
        end
        rst_n = 1;
        idle_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
